// File: rtl/idli_seq_m_pkg.sv
// Shared types for the nibble-serial sequencer: sync counter, register index and period kind.
package idli_seq_m_pkg;

    typedef logic [1:0] ctr_t;
    typedef logic [3:0] reg_t;

    typedef enum logic [1:0] {
        SEQ_KIND_BUBBLE = 2'd0,
        SEQ_KIND_INSN   = 2'd1,
        SEQ_KIND_IMM    = 2'd2,
        SEQ_KIND_MEM    = 2'd3
    } seq_kind_t;

    localparam ctr_t CTR_FIRST = 2'd0;
    localparam ctr_t CTR_LAST  = 2'd3;

endpackage

// File: rtl/idli_seq_m_if.sv
// Decode-facing bundle of the period sequencer; slave is the sequencer, master the decode/execute side.
interface idli_seq_m_if
    import idli_seq_m_pkg::*;
();

    logic      i_sq_stall;
    logic      i_sq_rhs_sqi;
    logic      i_sq_mem;
    reg_t      i_sq_mem_first;
    reg_t      i_sq_mem_last;
    logic      i_sq_skip;

    ctr_t      o_sq_ctr;
    seq_kind_t o_sq_kind;
    logic      o_sq_enc_vld;
    logic      o_sq_imm_vld;
    logic      o_sq_mem_vld;
    reg_t      o_sq_mem_reg;
    logic      o_sq_pc_inc;

    modport slave (
        input  i_sq_stall, i_sq_rhs_sqi, i_sq_mem, i_sq_mem_first, i_sq_mem_last, i_sq_skip,
        output o_sq_ctr, o_sq_kind, o_sq_enc_vld, o_sq_imm_vld, o_sq_mem_vld, o_sq_mem_reg, o_sq_pc_inc
    );

    modport master (
        output i_sq_stall, i_sq_rhs_sqi, i_sq_mem, i_sq_mem_first, i_sq_mem_last, i_sq_skip,
        input  o_sq_ctr, o_sq_kind, o_sq_enc_vld, o_sq_imm_vld, o_sq_mem_vld, o_sq_mem_reg, o_sq_pc_inc
    );

endinterface

// File: rtl/idli_seq_m.sv
// 4-GCK period sequencer: classifies each bus period and walks memory register beats.
// Optional feature macro IDLI_SEQ_SKIP_EN: a failed condition suppresses memory beats.
module idli_seq_m
    import idli_seq_m_pkg::*;
(
    input  logic          i_sq_gck,
    input  logic          i_sq_rst,
    idli_seq_m_if.slave   sq
);

    ctr_t      ctr_q,     ctr_d;
    seq_kind_t kind_q,    kind_d;
    reg_t      mem_reg_q, mem_reg_d;
    reg_t      first_q,   first_d;
    reg_t      last_q,    last_d;
    logic      pend_q,    pend_d;
    logic      new_q,     new_d;

    logic      mem_eff_s;
    logic      resolve_s;
    logic      boundary_s;
    seq_kind_t dec_kind_s;
    seq_kind_t kind_s;

`ifdef IDLI_SEQ_SKIP_EN
    assign mem_eff_s = sq.i_sq_mem & ~sq.i_sq_skip;
`else
    logic unused_skip_s;
    assign mem_eff_s     = sq.i_sq_mem;
    assign unused_skip_s = sq.i_sq_skip;
`endif

    assign resolve_s  = new_q & (ctr_q == CTR_FIRST);
    assign boundary_s = (ctr_q == CTR_LAST) & ~sq.i_sq_stall;

    // Period-kind resolution from decode and the visible kind for this cycle.
    always_comb begin
        dec_kind_s = SEQ_KIND_INSN;
        if (sq.i_sq_rhs_sqi) begin
            dec_kind_s = SEQ_KIND_IMM;
        end else if (mem_eff_s) begin
            dec_kind_s = SEQ_KIND_MEM;
        end else begin
            dec_kind_s = SEQ_KIND_INSN;
        end
        kind_s = resolve_s ? dec_kind_s : kind_q;
    end

    // Next-state logic: ctr==0 decode resolution and ctr==3 period transitions.
    always_comb begin
        ctr_d     = ctr_q + 2'd1;
        kind_d    = kind_s;
        mem_reg_d = mem_reg_q;
        first_d   = first_q;
        last_d    = last_q;
        pend_d    = pend_q;
        new_d     = new_q;

        if (resolve_s) begin
            new_d   = 1'b0;
            first_d = sq.i_sq_mem_first;
            last_d  = sq.i_sq_mem_last;
            case (dec_kind_s)
                SEQ_KIND_IMM: pend_d = mem_eff_s;
                SEQ_KIND_MEM: begin
                    mem_reg_d = sq.i_sq_mem_first;
                    pend_d    = 1'b0;
                end
                default:      pend_d = 1'b0;
            endcase
        end else begin
            new_d = new_q;
        end

        // A stalled boundary leaves kind, beat and new_q untouched so the period repeats.
        if (boundary_s) begin
            case (kind_q)
                SEQ_KIND_BUBBLE: kind_d = SEQ_KIND_INSN;
                SEQ_KIND_INSN:   new_d  = 1'b1;
                SEQ_KIND_IMM: begin
                    if (pend_q) begin
                        kind_d    = SEQ_KIND_MEM;
                        mem_reg_d = first_q;
                        pend_d    = 1'b0;
                    end else begin
                        kind_d    = SEQ_KIND_INSN;
                    end
                end
                SEQ_KIND_MEM: begin
                    if (mem_reg_q == last_q) begin
                        kind_d    = SEQ_KIND_INSN;
                    end else begin
                        mem_reg_d = mem_reg_q + 4'd1;
                    end
                end
                default:         kind_d = SEQ_KIND_BUBBLE;
            endcase
        end else begin
            kind_d = kind_s;
        end
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge i_sq_gck) begin
        if (i_sq_rst) begin
            ctr_q     <= 2'd0;
            kind_q    <= SEQ_KIND_BUBBLE;
            mem_reg_q <= 4'd0;
            first_q   <= 4'd0;
            last_q    <= 4'd0;
            pend_q    <= 1'b0;
            new_q     <= 1'b0;
        end else begin
            ctr_q     <= ctr_d;
            kind_q    <= kind_d;
            mem_reg_q <= mem_reg_d;
            first_q   <= first_d;
            last_q    <= last_d;
            pend_q    <= pend_d;
            new_q     <= new_d;
        end
    end

    // Output strobes derived from the registered state and the boundary stall.
    always_comb begin
        sq.o_sq_ctr     = ctr_q;
        sq.o_sq_kind    = kind_s;
        sq.o_sq_imm_vld = (kind_s == SEQ_KIND_IMM);
        sq.o_sq_mem_vld = (kind_s == SEQ_KIND_MEM);
        sq.o_sq_enc_vld = (kind_s == SEQ_KIND_INSN) & boundary_s;
        sq.o_sq_pc_inc  = ((kind_s == SEQ_KIND_INSN) | (kind_s == SEQ_KIND_IMM)) & boundary_s;
        if (resolve_s && (dec_kind_s == SEQ_KIND_MEM)) begin
            sq.o_sq_mem_reg = sq.i_sq_mem_first;
        end else begin
            sq.o_sq_mem_reg = mem_reg_q;
        end
    end

endmodule
